// File: rtl/scan_sequencer.sv
// scan_sequencer: latches the pose, then streams scan points to a pool
// of Bresenham engines round-robin, with optional grid clear and abort.
module scan_sequencer #(
  parameter int NUM_ENGINES = 2,
  parameter int SCAN_POINTS = 360,
  parameter int ADDR_WIDTH  = 9,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear_request,
  input  logic                   abort,
  input  logic                   occupancy_busy,
  input  logic [NUM_ENGINES-1:0] engine_busy,
  output logic [ADDR_WIDTH-1:0]  scan_addr,
  output logic                   position_enable,
  output logic [NUM_ENGINES-1:0] engine_start,
  output logic                   zero_grid,
  output logic                   use_engine_indices,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [ADDR_WIDTH-1:0]  points_issued
);

  localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SCAN_POINTS);
  localparam logic [2:0] LAT_END = 3'(MEM_LATENCY - 1);

  if (2**ADDR_WIDTH <= SCAN_POINTS) begin : g_bad_addr_width
    $error("scan_sequencer: ADDR_WIDTH too small for SCAN_POINTS");
  end
  if (NUM_ENGINES < 1 || NUM_ENGINES > 8) begin : g_bad_engines
    $error("scan_sequencer: NUM_ENGINES out of range 1..8");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("scan_sequencer: MEM_LATENCY out of range 1..4");
  end

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    CLEAR_WAIT,
    POSE_WAIT,
    POSE_LATCH,
    FETCH,
    DISPATCH,
    DRAIN,
    DONE,
    ABORT_DRAIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_WIDTH-1:0]  addr_n;
  logic [ADDR_WIDTH-1:0]  issued_n;
  logic [2:0]             cnt;
  logic [2:0]             cnt_n;
  logic [PW-1:0]          rr;
  logic [PW-1:0]          rr_n;
  logic [NUM_ENGINES-1:0] last_start;
  logic [NUM_ENGINES-1:0] free;
  logic [NUM_ENGINES-1:0] grant;
  logic [PW-1:0]          grant_idx;
  logic                   found;
  logic                   drained;
  logic                   abortable;

  // An engine started last cycle has not raised busy yet
  assign free = ~engine_busy & ~last_start;

  assign drained = ~|engine_busy & ~occupancy_busy & ~|last_start;

  assign abortable = (state != IDLE) && (state != DONE) &&
                     (state != ABORT_DRAIN);

  assign busy = (state != IDLE);

  assign use_engine_indices = (state == FETCH) || (state == DISPATCH) ||
                              (state == DRAIN) || (state == ABORT_DRAIN);

  // First free engine at or after the round-robin pointer
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_ENGINES) j = j - NUM_ENGINES;
      if (!found && free[j[PW-1:0]]) begin
        found = 1'b1;
        grant[j[PW-1:0]] = 1'b1;
        grant_idx = j[PW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // Next state, strobes and datapath updates; abort overrides everything
  always_comb begin
    state_n = state;
    addr_n = scan_addr;
    issued_n = points_issued;
    cnt_n = cnt;
    rr_n = rr;
    zero_grid = 1'b0;
    position_enable = 1'b0;
    engine_start = '0;
    done = 1'b0;
    aborted = 1'b0;
    if (abort && abortable) begin
      state_n = ABORT_DRAIN;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !occupancy_busy) begin
            state_n = clear_request ? CLEAR : POSE_WAIT;
            addr_n = '0;
            issued_n = '0;
            cnt_n = '0;
          end
        end
        CLEAR: begin
          zero_grid = 1'b1;
          cnt_n = '0;
          state_n = CLEAR_WAIT;
        end
        CLEAR_WAIT: begin
          if (cnt == 3'd0) begin
            cnt_n = 3'd1;
          end else if (!occupancy_busy) begin
            cnt_n = '0;
            state_n = POSE_WAIT;
          end
        end
        POSE_WAIT: begin
          if (cnt == LAT_END) begin
            cnt_n = '0;
            state_n = POSE_LATCH;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        POSE_LATCH: begin
          position_enable = 1'b1;
          addr_n = ADDR_WIDTH'(1);
          cnt_n = '0;
          state_n = FETCH;
        end
        FETCH: begin
          if (cnt == LAT_END) begin
            cnt_n = '0;
            state_n = DISPATCH;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        DISPATCH: begin
          if (!occupancy_busy && found) begin
            engine_start = grant;
            addr_n = scan_addr + 1'b1;
            issued_n = points_issued + 1'b1;
            cnt_n = '0;
            if (grant_idx == PW'(NUM_ENGINES - 1)) rr_n = '0;
            else rr_n = grant_idx + 1'b1;
            if (points_issued + 1'b1 == LAST) state_n = DRAIN;
            else state_n = FETCH;
          end
        end
        DRAIN: begin
          if (drained) state_n = DONE;
        end
        DONE: begin
          done = 1'b1;
          addr_n = '0;
          state_n = IDLE;
        end
        ABORT_DRAIN: begin
          if (drained) begin
            aborted = 1'b1;
            addr_n = '0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Address, count, latency counter, round-robin pointer, start history
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_addr <= '0;
      points_issued <= '0;
      cnt <= '0;
      rr <= '0;
      last_start <= '0;
    end else begin
      scan_addr <= addr_n;
      points_issued <= issued_n;
      cnt <= cnt_n;
      rr <= rr_n;
      last_start <= engine_start;
    end
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter NUM_ENGINES, default 2: number of parallel Bresenham engines dispatched, range 1..8.
REQ-002 Parameter SCAN_POINTS, default 360: scan points per pass, stored at scan memory addresses 1..SCAN_POINTS.
REQ-003 Parameter ADDR_WIDTH, default 9: scan memory address width; 2**ADDR_WIDTH > SCAN_POINTS is checked at elaboration.
REQ-004 Parameter MEM_LATENCY, default 1: cycles from a scan_addr change to valid read data, range 1..4.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  level request to begin one scan pass.
REQ-008 clear_request  in  1  sampled with the accepted start; 1 = zero the occupancy grid before the pass.
REQ-009 abort  in  1  terminate the current pass.
REQ-010 occupancy_busy  in  1  occupancy grid is clearing or updating.
REQ-011 engine_busy  in  NUM_ENGINES  per-engine busy flags.
REQ-012 scan_addr  out  ADDR_WIDTH  scan memory read address; address 0 holds the pose.
REQ-013 position_enable  out  1  one-cycle pose-register load strobe.
REQ-014 engine_start  out  NUM_ENGINES  one-hot start pulse, one cycle.
REQ-015 zero_grid  out  1  one-cycle grid-clear strobe.
REQ-016 use_engine_indices  out  1  occupancy grid addressed by the engines instead of the host.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when a pass completes normally.
REQ-019 aborted  out  1  one-cycle pulse when an aborted pass reaches idle.
REQ-020 points_issued  out  ADDR_WIDTH  count of points dispatched in the current pass.

Function
REQ-021 The FSM SHALL have states IDLE, CLEAR, CLEAR_WAIT, POSE_WAIT, POSE_LATCH, FETCH, DISPATCH, DRAIN, DONE, ABORT_DRAIN.
REQ-022 IDLE: start=1 and occupancy_busy=0 -> CLEAR if clear_request=1, else POSE_WAIT; start while occupancy_busy=1 is ignored, not queued.
REQ-023 CLEAR: zero_grid=1 for one cycle -> CLEAR_WAIT; CLEAR_WAIT lasts at least 2 cycles, then exits to POSE_WAIT on occupancy_busy=0.
REQ-024 POSE_WAIT: scan_addr=0 and points_issued=0, held MEM_LATENCY cycles -> POSE_LATCH.
REQ-025 POSE_LATCH: position_enable=1 for one cycle, scan_addr<=1 -> FETCH.
REQ-026 FETCH: hold scan_addr for MEM_LATENCY cycles -> DISPATCH.
REQ-027 An engine is free when engine_busy[i]=0 and it received no engine_start in the previous cycle; this covers the engine's one-cycle busy-rise delay.
REQ-028 DISPATCH: if occupancy_busy=0 and a free engine exists, pulse engine_start for the engine chosen round-robin, beginning at the index after the last grant (engine 0 after reset), and increment scan_addr and points_issued; otherwise stay in DISPATCH with no pulse.
REQ-029 After a dispatch, points_issued=SCAN_POINTS -> DRAIN; otherwise -> FETCH.
REQ-030 DRAIN: exit to DONE when all engine_busy=0, occupancy_busy=0 and no start was issued in the previous cycle.
REQ-031 DONE: done=1 for one cycle, scan_addr<=0 -> IDLE.
REQ-032 use_engine_indices=1 in FETCH, DISPATCH, DRAIN and ABORT_DRAIN, and 0 elsewhere.
REQ-033 abort=1 in any non-IDLE state except DONE -> ABORT_DRAIN, with no further engine_start, zero_grid or position_enable; abort in IDLE or DONE is ignored.
REQ-034 ABORT_DRAIN: wait on the DRAIN condition, then pulse aborted=1 for one cycle, scan_addr<=0 -> IDLE; done is not pulsed.
REQ-035 If abort and a dispatch condition occur in the same cycle, abort wins and no engine_start is issued.
REQ-036 At most one engine_start bit SHALL be high in any cycle, and strobes never overlap.

Reset
REQ-037 Reset SHALL force IDLE, all outputs to 0, scan_addr=0, points_issued=0 and the round-robin pointer to engine 0; reset mid-pass abandons the pass without a done or aborted pulse.

Verification
REQ-038 NUM_ENGINES=2, SCAN_POINTS=4, engines busy 3 cycles; start, clear_request=0 -> position_enable at addr 0, engine_start 01,10,01,10 at addrs 1..4, then done one pulse; points_issued=4.
REQ-039 start with clear_request=1 and occupancy_busy high for 5 cycles after zero_grid -> zero_grid one pulse; position_enable only after occupancy_busy falls.
REQ-040 Both engines held busy for 20 cycles during DISPATCH -> no engine_start and scan_addr constant until an engine frees.
REQ-041 abort after 2 dispatches while engine 1 busy -> no further starts, aborted one pulse after engine_busy=0, done never high.
REQ-042 start held while occupancy_busy=1 -> busy stays 0; reset asserted mid-DISPATCH -> all outputs 0 next cycle.
REQ-043 MEM_LATENCY=3 -> exactly 3 cycles between each scan_addr change and the corresponding engine_start.
